string_case_conv: RTL and testbench

//  Streaming ASCII case converter. It accepts a byte stream framed into strings
//  (valid/ready/last) and emits each byte converted to the case mode that was latched
//  on the first byte of that string.
//  It reports per-string length and changed-byte counts on the last output beat.
//  It is the datapath stage the stringcase bench drives as its DUT; a text source sits

---
 rtl/string_case_conv.sv | 158 +++++++++++++++
 tb/tb_string_case_conv.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_case_conv.sv
// Streaming ASCII case converter: converts each byte of a valid/ready/last framed
// string using the mode latched on its first byte, and reports length/changed counts.
module string_case_conv #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] out_len,
   output logic [CNT_W-1:0] out_chg
);
   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [1:0] MODE_PASS  = 2'd0;
   localparam logic [1:0] MODE_UPPER = 2'd1;
   localparam logic [1:0] MODE_LOWER = 2'd2;
   localparam logic [1:0] MODE_TITLE = 2'd3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [7:0]       data;
      logic             last;
      logic [CNT_W-1:0] len;
      logic [CNT_W-1:0] chg;
   } beat_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic             title_q, title_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] chg_q, chg_d;
   logic             in_ready_q, in_ready_d;
   logic             skid_full_q, skid_full_d;
   beat_t            skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   beat_t            out_q, out_d;

   logic             accept;
   logic             out_load;
   logic [1:0]       cur_mode;
   logic             cur_title;
   logic [CNT_W-1:0] base_len;
   logic [CNT_W-1:0] base_chg;
   logic             is_upper;
   logic             is_lower;
   logic             flip;
   beat_t            new_beat;

   always_comb begin
      accept = in_valid & in_ready_q;

      // A beat seen in IDLE opens a new string, so it uses fresh context, not the registers
      if (state_q == IDLE) begin
         cur_mode  = in_mode;
         cur_title = 1'b1;
         base_len  = '0;
         base_chg  = '0;
      end else begin
         cur_mode  = mode_q;
         cur_title = title_q;
         base_len  = len_q;
         base_chg  = chg_q;
      end

      is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
      is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A);
      flip     = 1'b0;
      case (cur_mode)
         MODE_PASS:  flip = 1'b0;
         MODE_UPPER: flip = is_lower;
         MODE_LOWER: flip = is_upper;
         MODE_TITLE: flip = cur_title ? is_lower : is_upper;
      endcase

      new_beat.data = in_data ^ {2'b00, flip, 5'b00000};
      new_beat.last = in_last;
      new_beat.len  = (base_len == CNT_MAX) ? base_len : base_len + CNT_ONE;
      new_beat.chg  = (flip && (base_chg != CNT_MAX)) ? base_chg + CNT_ONE : base_chg;

      state_d = state_q;
      mode_d  = mode_q;
      title_d = title_q;
      len_d   = len_q;
      chg_d   = chg_q;
      if (accept) begin
         mode_d  = cur_mode;
         title_d = (in_data == 8'h20) || (in_data == 8'h09);
         len_d   = new_beat.len;
         chg_d   = new_beat.chg;
         state_d = in_last ? IDLE : ACTIVE;
      end

      // The skid entry is always older than anything arriving, so it drains first
      out_load    = !out_valid_q || out_ready;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      skid_full_d = skid_full_q;
      skid_d      = skid_q;
      if (out_load) begin
         if (skid_full_q) begin
            out_valid_d = 1'b1;
            out_d       = skid_q;
            skid_full_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = new_beat;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d      = new_beat;
         skid_full_d = 1'b1;
      end
      in_ready_d = !skid_full_d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         mode_q      <= MODE_PASS;
         title_q     <= 1'b1;
         len_q       <= '0;
         chg_q       <= '0;
         in_ready_q  <= 1'b0;
         skid_full_q <= 1'b0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         title_q     <= title_d;
         len_q       <= len_d;
         chg_q       <= chg_d;
         in_ready_q  <= in_ready_d;
         skid_full_q <= skid_full_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q.data;
   assign out_last  = out_q.last;
   assign out_len   = out_q.len;
   assign out_chg   = out_q.chg;
endmodule

// File: tb/tb_string_case_conv.sv
// Bench for string_case_conv: two instances (CNT_W=16 and CNT_W=4) share one stimulus
// and are checked every cycle against a string-level model of the conversion rules.
module tb_string_case_conv;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic [1:0]  in_mode = 2'd0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, out_last_a;
   logic [7:0]  out_data_a;
   logic [15:0] out_len_a, out_chg_a;
   logic        in_ready_b, out_valid_b, out_last_b;
   logic [7:0]  out_data_b;
   logic [3:0]  out_len_b, out_chg_b;

   string_case_conv #(.CNT_W(16)) dut_a (
      .Clk(Clk), .Reset(Reset),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
      .in_mode(in_mode), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_last(out_last_a), .out_len(out_len_a), .out_chg(out_chg_a)
   );

   string_case_conv #(.CNT_W(4)) dut_b (
      .Clk(Clk), .Reset(Reset),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
      .in_mode(in_mode), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_last(out_last_b), .out_len(out_len_b), .out_chg(out_chg_b)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] data;
      bit         last;
      int         len;
      int         chg;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cur_e;
   logic [7:0] got_q[$];
   int         errors = 0;
   int         checks = 0;
   int         fire_cnt = 0;
   int         cyc = 0;
   int         ready_low_cnt = 0;
   int         last_len_a = -1, last_chg_a = -1, last_len_b = -1, last_chg_b = -1;
   bit         stall_en = 1'b0;
   int         pat_idx = 0;
   bit         pat[6] = '{1, 0, 0, 1, 0, 1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic check_seq(input string name, input string req);
      int bad = -1;
      checks++;
      for (int i = 0; i < req.len(); i++)
         if (bad < 0 && (i >= got_q.size() || got_q[i] !== req[i])) bad = i;
      if (bad < 0 && got_q.size() != req.len()) bad = req.len();
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: got %0d bytes, required %0d (\"%s\"), first difference at %0d",
                  name, got_q.size(), req.len(), req, bad);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   // Byte i of string s under mode; title capitalisation depends only on the previous byte
   function automatic logic [7:0] model_byte(input string s, input int i, input logic [1:0] mode);
      logic [7:0] c = s[i];
      bit up = (c >= 8'h41) && (c <= 8'h5A);
      bit lo = (c >= 8'h61) && (c <= 8'h7A);
      bit cap = (i == 0) || (s[i-1] == 8'h20) || (s[i-1] == 8'h09);
      case (mode)
         2'd1: return lo ? c - 8'h20 : c;
         2'd2: return up ? c + 8'h20 : c;
         2'd3: if (cap) return lo ? c - 8'h20 : c;
               else     return up ? c + 8'h20 : c;
         default: return c;
      endcase
   endfunction

   task automatic pin(input string name, input string s, input logic [1:0] mode,
                      input string want, input int want_chg);
      int chg = 0;
      got_q.delete();
      for (int i = 0; i < s.len(); i++) begin
         got_q.push_back(model_byte(s, i, mode));
         if (model_byte(s, i, mode) != s[i]) chg++;
      end
      check_seq(name, want);
      check({name, "_chg"}, 32'(chg), 32'(want_chg));
      got_q.delete();
   endtask

   task automatic push_expect(input string s, input logic [1:0] mode);
      int chg = 0;
      exp_t e;
      for (int i = 0; i < s.len(); i++) begin
         e.data = model_byte(s, i, mode);
         if (e.data != s[i]) chg++;
         e.last = (i == s.len() - 1);
         e.len  = i + 1;
         e.chg  = chg;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_accept();
      bit acc = 1'b0;
      int guard = 0;
      do begin
         @(negedge Clk);
         acc = in_ready_a;
         @(posedge Clk);
         #1;
         guard++;
      end while (!acc && guard < 200);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   // Sends the first nsend bytes of s (all if nsend<0); in_mode switches to mode2 from byte chg_at on
   task automatic send(input string s, input logic [1:0] mode, input int chg_at,
                       input logic [1:0] mode2, input int nsend);
      int n = (nsend < 0) ? s.len() : nsend;
      push_expect(s, mode);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = s[i];
         in_last  = (i == s.len() - 1);
         in_mode  = (chg_at >= 0 && i >= chg_at) ? mode2 : mode;
         wait_accept();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge Clk);
         #1;
         guard++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   always @(posedge Clk) cyc <= cyc + 1;

   always begin
      @(posedge Clk);
      #1;
      if (stall_en) begin
         out_ready = pat[pat_idx];
         pat_idx = (pat_idx + 1) % 6;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Per-cycle comparison of both instances against the expected-beat queue
   always begin
      @(negedge Clk);
      if (!Reset) begin
         check("valid_w4", 32'(out_valid_b), 32'(out_valid_a));
         check("in_ready_w4", 32'(in_ready_b), 32'(in_ready_a));
         if (!in_ready_a) ready_low_cnt++;
         if (out_valid_a) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h, required no output", out_data_a);
            end else begin
               cur_e = exp_q[0];
               check("data", 32'(out_data_a), 32'(cur_e.data));
               check("data_w4", 32'(out_data_b), 32'(cur_e.data));
               check("last", 32'(out_last_a), 32'(cur_e.last));
               check("last_w4", 32'(out_last_b), 32'(cur_e.last));
               if (cur_e.last) begin
                  check("len", 32'(out_len_a), 32'(sat(cur_e.len, 16)));
                  check("chg", 32'(out_chg_a), 32'(sat(cur_e.chg, 16)));
                  check("len_w4", 32'(out_len_b), 32'(sat(cur_e.len, 4)));
                  check("chg_w4", 32'(out_chg_b), 32'(sat(cur_e.chg, 4)));
               end
               if (out_ready) begin
                  if (cur_e.last) begin
                     last_len_a = int'(out_len_a);
                     last_chg_a = int'(out_chg_a);
                     last_len_b = int'(out_len_b);
                     last_chg_b = int'(out_chg_b);
                  end
                  got_q.push_back(out_data_a);
                  void'(exp_q.pop_front());
                  fire_cnt++;
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid_a), 32'd0);
      check({tag, "_out_data"}, 32'(out_data_a), 32'd0);
      check({tag, "_out_last"}, 32'(out_last_a), 32'd0);
      check({tag, "_out_len"}, 32'(out_len_a), 32'd0);
      check({tag, "_out_chg"}, 32'(out_chg_a), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready_a), 32'd0);
      check({tag, "_out_valid_w4"}, 32'(out_valid_b), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, f0;

      pin("pin_upper", "hello world", 2'd1, "HELLO WORLD", 10);
      pin("pin_title", "hELLO  wORLD", 2'd3, "Hello  World", 10);
      pin("pin_lower", "AbC1!", 2'd2, "abc1!", 2);
      pin("pin_title_tab", "x\351\tyZ", 2'd3, "X\351\tYz", 3);

      @(negedge Clk);
      check_reset_outputs("reset");
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      check("in_ready_before_edge", 32'(in_ready_a), 32'd0);
      @(negedge Clk);
      check("in_ready_after_edge", 32'(in_ready_a), 32'd1);
      @(posedge Clk);
      #1;

      // UPPER at full rate with one-cycle latency
      got_q.delete();
      t0 = cyc;
      f0 = fire_cnt;
      send("hello world", 2'd1, -1, 2'd0, -1);
      check("t1_input_cycles", 32'(cyc - t0), 32'd11);
      @(posedge Clk);
      #1;
      check("t1_output_beats", 32'(fire_cnt - f0), 32'd11);
      drain();
      check_seq("t1_out", "HELLO WORLD");
      check("t1_len", 32'(last_len_a), 32'd11);
      check("t1_chg", 32'(last_chg_a), 32'd10);

      got_q.delete();
      send("hELLO  wORLD", 2'd3, -1, 2'd0, -1);
      drain();
      check_seq("t2_out", "Hello  World");
      check("t2_len", 32'(last_len_a), 32'd12);
      check("t2_chg", 32'(last_chg_a), 32'd10);

      // LOWER under a repeating output stall pattern
      got_q.delete();
      stall_en = 1'b1;
      @(posedge Clk);
      #1;
      ready_low_cnt = 0;
      send("AbC1!", 2'd2, -1, 2'd0, -1);
      drain();
      stall_en = 1'b0;
      @(posedge Clk);
      #1;
      check_seq("t3_out", "abc1!");
      check("t3_len", 32'(last_len_a), 32'd5);
      check("t3_chg", 32'(last_chg_a), 32'd2);
      check("t3_in_ready_dropped", 32'(ready_low_cnt != 0), 32'd1);

      // Mode change mid-string is ignored; next string latches its own mode
      got_q.delete();
      send("abcd", 2'd1, 2, 2'd2, -1);
      send("XY", 2'd2, -1, 2'd0, -1);
      drain();
      check_seq("t4_out", "ABCDxy");

      // One-byte string, high bytes, tab, and PASS
      got_q.delete();
      send("q", 2'd1, -1, 2'd0, -1);
      send("x\351\tyZ", 2'd3, -1, 2'd0, -1);
      send("MiXeD", 2'd0, -1, 2'd0, -1);
      drain();
      check_seq("t_misc_out", "QX\351\tYzMiXeD");
      check("t_misc_pass_chg", 32'(last_chg_a), 32'd0);

      // Reset while a string is in flight
      send("wxyz", 2'd1, -1, 2'd0, 3);
      check("t5_valid_before_reset", 32'(out_valid_a), 32'd1);
      Reset = 1'b1;
      #1;
      check_reset_outputs("t5_reset");
      exp_q.delete();
      got_q.delete();
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      check("t5_in_ready_before_edge", 32'(in_ready_a), 32'd0);
      @(posedge Clk);
      #1;
      send("ab", 2'd1, -1, 2'd0, -1);
      drain();
      check_seq("t5_out", "AB");
      check("t5_len", 32'(last_len_a), 32'd2);
      check("t5_chg", 32'(last_chg_a), 32'd2);

      // Counter saturation on the narrow instance
      got_q.delete();
      send("aaaaaaaaaaaaaaaaaaaa", 2'd1, -1, 2'd0, -1);
      drain();
      check_seq("t6_out", "AAAAAAAAAAAAAAAAAAAA");
      check("t6_len_w16", 32'(last_len_a), 32'd20);
      check("t6_len_w4", 32'(last_len_b), 32'd15);
      check("t6_chg_w4", 32'(last_chg_b), 32'd15);

      repeat (3) @(posedge Clk);
      #1;
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
